// File: rtl/uart_baud_if.sv
// Control/status bundle of the fractional UART baud generator.
// The master drives the divisor and control inputs; the slave (the generator) drives the tick strobes.
interface uart_baud_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              rx_restart;
    logic              rx_tick;
    logic              tx_tick;
    logic              rx_sample;

    modport master (
        output en, div_int, div_frac, div_load, rx_restart,
        input  rx_tick, tx_tick, rx_sample
    );

    modport slave (
        input  en, div_int, div_frac, div_load, rx_restart,
        output rx_tick, tx_tick, rx_sample
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional-N UART baud generator: oversample tick, bit-rate tick and a re-phaseable
// mid-bit sampling strobe, with a glitch-free shadowed divisor.
module uart_baud_gen #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         rst,
    uart_baud_if.slave   bus
);
    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

    // Interval state
    logic [DIV_W-1:0]  cnt_reg;
    logic [FRAC_W-1:0] acc_reg;
    logic [DIV_W:0]    len_reg;

    // Active divisor (used by running intervals) and shadow divisor (written by div_load)
    logic [DIV_W-1:0]  act_int_reg;
    logic [FRAC_W-1:0] act_frac_reg;
    logic [DIV_W-1:0]  sh_int_reg;
    logic [FRAC_W-1:0] sh_frac_reg;

    // Oversample counters and registered strobes
    logic [OS_W-1:0]   tx_os_reg;
    logic [OS_W-1:0]   rx_os_reg;
    logic              rx_tick_reg;
    logic              tx_tick_reg;
    logic              rx_sample_reg;

    // Combinational interval bookkeeping
    logic [DIV_W-1:0]  eff_int;
    logic [FRAC_W:0]   frac_sum;
    logic              start;
    logic [DIV_W:0]    len_now;
    logic              boundary;

    always_comb begin
        eff_int  = (act_int_reg == '0) ? DIV_W'(1) : act_int_reg;
        frac_sum = {1'b0, acc_reg} + {1'b0, act_frac_reg};
        start    = (cnt_reg == '0);
        // The length is fixed on the first cycle of an interval and then held in len_reg,
        // so a divisor change can never stretch or cut an interval already in progress.
        len_now  = start ? ({1'b0, eff_int} + {{DIV_W{1'b0}}, frac_sum[FRAC_W]}) : len_reg;
        boundary = ({1'b0, cnt_reg} == (len_now - (DIV_W+1)'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_int_reg  <= DIV_W'(1);
            sh_frac_reg <= '0;
        end else if (bus.div_load) begin
            sh_int_reg  <= bus.div_int;
            sh_frac_reg <= bus.div_frac;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            acc_reg       <= '0;
            len_reg       <= (DIV_W+1)'(1);
            act_int_reg   <= DIV_W'(1);
            act_frac_reg  <= '0;
            tx_os_reg     <= '0;
            rx_os_reg     <= '0;
            rx_tick_reg   <= 1'b0;
            tx_tick_reg   <= 1'b0;
            rx_sample_reg <= 1'b0;
        end else if (!bus.en) begin
            cnt_reg       <= '0;
            acc_reg       <= '0;
            len_reg       <= (DIV_W+1)'(1);
            act_int_reg   <= sh_int_reg;
            act_frac_reg  <= sh_frac_reg;
            tx_os_reg     <= '0;
            rx_os_reg     <= '0;
            rx_tick_reg   <= 1'b0;
            tx_tick_reg   <= 1'b0;
            rx_sample_reg <= 1'b0;
        end else begin
            if (start) begin
                acc_reg <= frac_sum[FRAC_W-1:0];
                len_reg <= len_now;
            end

            if (boundary) begin
                cnt_reg     <= '0;
                rx_tick_reg <= 1'b1;
                // A load on the boundary edge bypasses the shadow so the very next interval uses it
                act_int_reg  <= bus.div_load ? bus.div_int  : sh_int_reg;
                act_frac_reg <= bus.div_load ? bus.div_frac : sh_frac_reg;
                if (tx_os_reg == OS_LAST) begin
                    tx_os_reg   <= '0;
                    tx_tick_reg <= 1'b1;
                end else begin
                    tx_os_reg   <= tx_os_reg + OS_W'(1);
                    tx_tick_reg <= 1'b0;
                end
            end else begin
                cnt_reg     <= cnt_reg + DIV_W'(1);
                rx_tick_reg <= 1'b0;
                tx_tick_reg <= 1'b0;
            end

            // Restart re-phases the sampling strobe half a bit ahead and swallows a coincident tick
            if (bus.rx_restart) begin
                rx_os_reg     <= OS_HALF;
                rx_sample_reg <= 1'b0;
            end else if (boundary) begin
                if (rx_os_reg == OS_LAST) begin
                    rx_os_reg     <= '0;
                    rx_sample_reg <= 1'b1;
                end else begin
                    rx_os_reg     <= rx_os_reg + OS_W'(1);
                    rx_sample_reg <= 1'b0;
                end
            end else begin
                rx_sample_reg <= 1'b0;
            end
        end
    end

    assign bus.rx_tick   = rx_tick_reg;
    assign bus.tx_tick   = tx_tick_reg;
    assign bus.rx_sample = rx_sample_reg;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: table of divisor vectors plus hand-written
// sequences, with expected strobe cycles scheduled into queues and matched as they occur.
module tb_uart_baud_gen;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OS     = 16;

    logic clk;
    logic rst;

    uart_baud_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

    uart_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int div_int;
        int div_frac;
        int n_cycles;
        int exp_rx;
        int exp_tx;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rx_seen  = 0;
    int tx_seen  = 0;
    int rxq[$];
    int txq[$];
    int sq[$];

    // Compare one strobe whenever it is observed high or is scheduled for this cycle
    task automatic chk_evt(input int idx, input logic obs);
        int    exp_t;
        int    dummy;
        bit    due;
        string nm;
        exp_t = -1;
        case (idx)
            0: begin nm = "rx_tick";   if (rxq.size() > 0) exp_t = rxq[0]; end
            1: begin nm = "tx_tick";   if (txq.size() > 0) exp_t = txq[0]; end
            default: begin nm = "rx_sample"; if (sq.size() > 0) exp_t = sq[0]; end
        endcase
        due = (exp_t == cyc);
        if (obs || due) begin
            checks++;
            if (due) begin
                case (idx)
                    0: dummy = rxq.pop_front();
                    1: dummy = txq.pop_front();
                    default: dummy = sq.pop_front();
                endcase
            end
            if (!(obs && due)) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%0b required=%0b next_scheduled=%0d",
                         nm, cyc, obs, due, exp_t);
            end
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.rx_tick) rx_seen++;
        if (bus.tx_tick) tx_seen++;
        chk_evt(0, bus.rx_tick);
        chk_evt(1, bus.tx_tick);
        chk_evt(2, bus.rx_sample);
    endtask

    task automatic run_until(input int target);
        while (cyc < target) tick_cycle();
    endtask

    task automatic chk_zero(input string nm);
        checks++;
        if ({bus.rx_tick, bus.tx_tick, bus.rx_sample} != 3'b000) begin
            failures++;
            $display("FAIL %s outputs rx/tx/sample=%0b%0b%0b required=000",
                     nm, bus.rx_tick, bus.tx_tick, bus.rx_sample);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", nm, got, want);
        end
    endtask

    task automatic end_check(input string nm);
        chk_int({nm, " rx_tick left"},   rxq.size(), 0);
        chk_int({nm, " tx_tick left"},   txq.size(), 0);
        chk_int({nm, " rx_sample left"}, sq.size(),  0);
        rxq.delete();
        txq.delete();
        sq.delete();
    endtask

    // Tick k of a fresh run lands on edge k*int + floor(k*frac / 2^FRAC_W)
    task automatic push_sched(input int di, input int df, input int last, input bit do_sample);
        int eff;
        int t;
        int k;
        eff = (di == 0) ? 1 : di;
        k   = 1;
        t   = eff + ((df) >> FRAC_W);
        while (t <= last) begin
            rxq.push_back(t);
            if ((k % OS) == 0) begin
                txq.push_back(t);
                if (do_sample) sq.push_back(t);
            end
            k++;
            t = k * eff + ((k * df) >> FRAC_W);
        end
    endtask

    // Load a divisor while disabled and let it settle into the active register
    task automatic prep(input int di, input int df);
        bus.en       = 1'b0;
        bus.div_int  = DIV_W'(di);
        bus.div_frac = FRAC_W'(df);
        bus.div_load = 1'b1;
        tick_cycle();
        bus.div_load = 1'b0;
        tick_cycle();
        tick_cycle();
        chk_zero("disabled idle");
    endtask

    task automatic start_run();
        bus.en  = 1'b1;
        cyc     = 0;
        rx_seen = 0;
        tx_seen = 0;
    endtask

    vec_t vecs[6];
    int   lst_a[7];

    initial begin
        vecs[0] = '{div_int: 4, div_frac: 0,  n_cycles: 130, exp_rx: 32, exp_tx: 2};
        vecs[1] = '{div_int: 4, div_frac: 8,  n_cycles: 144, exp_rx: 32, exp_tx: 2};
        vecs[2] = '{div_int: 0, div_frac: 0,  n_cycles: 40,  exp_rx: 40, exp_tx: 2};
        vecs[3] = '{div_int: 1, div_frac: 0,  n_cycles: 20,  exp_rx: 20, exp_tx: 1};
        vecs[4] = '{div_int: 3, div_frac: 5,  n_cycles: 100, exp_rx: 30, exp_tx: 1};
        vecs[5] = '{div_int: 1, div_frac: 15, n_cycles: 50,  exp_rx: 26, exp_tx: 1};
        lst_a   = '{4, 8, 12, 20, 28, 30, 32};

        rst            = 1'b1;
        bus.en         = 1'b0;
        bus.div_int    = '0;
        bus.div_frac   = '0;
        bus.div_load   = 1'b0;
        bus.rx_restart = 1'b0;
        repeat (3) tick_cycle();
        chk_zero("reset state");
        rst = 1'b0;
        tick_cycle();

        foreach (vecs[i]) begin
            prep(vecs[i].div_int, vecs[i].div_frac);
            start_run();
            push_sched(vecs[i].div_int, vecs[i].div_frac, vecs[i].n_cycles, 1'b1);
            run_until(vecs[i].n_cycles);
            end_check("vector");
            chk_int("vector rx_tick count", rx_seen, vecs[i].exp_rx);
            chk_int("vector tx_tick count", tx_seen, vecs[i].exp_tx);
            $display("vector %0d int=%0d frac=%0d cycles=%0d rx_ticks=%0d tx_ticks=%0d",
                     i, vecs[i].div_int, vecs[i].div_frac, vecs[i].n_cycles, rx_seen, tx_seen);
        end

        // Reload mid-interval, then reload exactly on a boundary edge
        prep(4, 0);
        start_run();
        foreach (lst_a[i]) rxq.push_back(lst_a[i]);
        run_until(9);
        bus.div_int  = DIV_W'(8);
        bus.div_load = 1'b1;
        tick_cycle();
        bus.div_load = 1'b0;
        run_until(27);
        bus.div_int  = DIV_W'(2);
        bus.div_load = 1'b1;
        tick_cycle();
        bus.div_load = 1'b0;
        run_until(33);
        end_check("reload");
        $display("sequence reload: int 4->8 mid-interval, 8->2 on boundary, rx_ticks=%0d", rx_seen);

        // Restart on a tick edge, then again on the edge where a sample was due
        prep(4, 0);
        start_run();
        push_sched(4, 0, 140, 1'b0);
        sq.push_back(40);
        sq.push_back(136);
        run_until(7);
        bus.rx_restart = 1'b1;
        tick_cycle();
        bus.rx_restart = 1'b0;
        run_until(103);
        bus.rx_restart = 1'b1;
        tick_cycle();
        bus.rx_restart = 1'b0;
        run_until(140);
        end_check("restart");
        $display("sequence restart: restarts at 8 and 104, tx_ticks=%0d", tx_seen);

        // Drop enable mid-interval; a restart while disabled must have no effect
        prep(4, 0);
        start_run();
        rxq.push_back(4);
        run_until(6);
        bus.en = 1'b0;
        tick_cycle();
        chk_zero("en low 1");
        bus.rx_restart = 1'b1;
        tick_cycle();
        chk_zero("en low 2");
        bus.rx_restart = 1'b0;
        tick_cycle();
        chk_zero("en low 3");
        end_check("enable drop");
        start_run();
        push_sched(4, 0, 70, 1'b1);
        run_until(70);
        end_check("re-enable");
        $display("sequence enable: dropped at 6, re-enabled, rx_ticks=%0d", rx_seen);

        // Reset two cycles ahead of a due tick, then divisor must be back to 1
        prep(4, 0);
        start_run();
        push_sched(4, 0, 9, 1'b1);
        run_until(9);
        rst = 1'b1;
        tick_cycle();
        chk_zero("reset mid-interval");
        rst    = 1'b0;
        bus.en = 1'b0;
        tick_cycle();
        chk_zero("after reset 1");
        tick_cycle();
        chk_zero("after reset 2");
        end_check("reset");
        start_run();
        push_sched(1, 0, 20, 1'b1);
        run_until(20);
        end_check("post-reset divisor");
        chk_int("post-reset rx_tick count", rx_seen, 20);
        $display("sequence reset: mid-interval reset, post-reset rx_ticks=%0d", rx_seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of the integer divisor and of the base counter.
REQ-002 SHALL have parameter FRAC_W, default 4: width of the fractional divisor and of the phase accumulator.
REQ-003 SHALL have parameter OVERSAMPLE, default 16: rx ticks per bit; legal values are even and >= 4.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: generator enable.
REQ-007 SHALL have port div_int, input, DIV_W bits: integer clocks per rx tick.
REQ-008 SHALL have port div_frac, input, FRAC_W bits: fractional part in units of 2^-FRAC_W.
REQ-009 SHALL have port div_load, input, 1 bit: capture div_int/div_frac into the shadow divisor.
REQ-010 SHALL have port rx_restart, input, 1 bit: re-phase the rx mid-bit strobe (start-edge detected).
REQ-011 SHALL have port rx_tick, output, 1 bit: one-cycle pulse at the oversample rate.
REQ-012 SHALL have port tx_tick, output, 1 bit: one-cycle pulse at the bit rate.
REQ-013 SHALL have port rx_sample, output, 1 bit: one-cycle mid-bit sampling strobe.

Function
REQ-014 SHALL hold an active divisor (int, frac); div_int==0 is treated as 1.
REQ-015 SHALL count the base counter 0..L-1 in each enabled cycle, with interval length L = int + c. c is the carry out of (acc + frac), computed once at interval start, and acc takes the FRAC_W-bit sum at that point.
REQ-016 SHALL register rx_tick to 1 for exactly one cycle per completed interval; the first rx_tick goes high L rising edges after the first edge at which en is sampled 1.
REQ-017 SHALL produce rx_tick high continuously while L==1.
REQ-018 SHALL count rx_ticks in tx_os_cnt modulo OVERSAMPLE, and assert tx_tick in the same cycle as the rx_tick that wraps tx_os_cnt to 0.
REQ-019 SHALL count rx_ticks in rx_os_cnt modulo OVERSAMPLE, and assert rx_sample in the same cycle as the rx_tick that wraps rx_os_cnt to 0.
REQ-020 SHALL load rx_os_cnt with OVERSAMPLE/2 on rx_restart, so rx_sample fires on the (OVERSAMPLE/2)-th rx_tick after restart, then every OVERSAMPLE rx_ticks.
REQ-021 SHALL give rx_restart priority over a coincident rx_tick; that tick is not counted by rx_os_cnt and rx_sample is 0 that cycle.
REQ-022 SHALL leave the base counter, acc, tx_os_cnt and tx_tick unaffected by rx_restart.
REQ-023 SHALL capture div_int/div_frac into the shadow on div_load.
REQ-024 SHALL transfer the shadow to the active divisor at the next interval boundary when en=1, or on the next edge when en=0; no interval is ever truncated or glitched.
REQ-025 SHALL, when div_load coincides with an interval boundary, apply the new value to the interval that starts next.
REQ-026 SHALL, while en=0, hold the base counter, acc, tx_os_cnt and rx_os_cnt at 0 and force all outputs to 0; rx_restart is ignored while en=0.
REQ-027 SHALL apply the priority rst > en=0 > rx_restart > counting.
REQ-028 SHALL use wrap-around arithmetic: the base counter never exceeds L-1; acc wraps modulo 2^FRAC_W; the os counters wrap modulo OVERSAMPLE.

Reset
REQ-029 SHALL, on rst=1 at a rising edge, clear the base counter, acc, tx_os_cnt, rx_os_cnt, rx_tick, tx_tick and rx_sample to 0.
REQ-030 SHALL, on rst=1, set the active and shadow divisors to int=1 and frac=0.
REQ-031 SHALL apply a reset asserted mid-interval on that edge, with no trailing pulse.

Verification
REQ-032 SHALL be verified with: OVERSAMPLE=16, load div_int=4 frac=0, en=1 -> rx_tick every 4 cycles (first on the 4th edge), tx_tick and rx_sample every 64 cycles, coincident.
REQ-033 SHALL be verified with: div_int=4 frac=8 (FRAC_W=4) -> rx_tick intervals 4,5,4,5...; 32 rx_ticks take exactly 144 cycles.
REQ-034 SHALL be verified with: div_load int=8 mid-interval of int=4 -> current 4-cycle interval completes, next interval is 8 cycles.
REQ-035 SHALL be verified with: rx_restart pulse, div_int=4 -> rx_sample on the 8th rx_tick after restart (32 cycles later if restart aligned to a boundary), then every 64 cycles; tx_tick phase unchanged.
REQ-036 SHALL be verified with: en dropped mid-interval, then raised -> outputs 0 while low; first rx_tick L edges after re-enable.
REQ-037 SHALL be verified with: rst asserted 2 cycles before an expected tick -> no tick; all outputs 0; divisor back to 1 (rx_tick every cycle once en=1).
